// File: rtl/dafx_frame_engine.sv
// dafx_frame_engine -- audio frame engine between the ADC beat stream and the mixer.
//
// Collects NR_OF_ADC_CHANNELS_P beats into one aligned frame. The frame ends on the
// beat that carries adc_last. Synthesiser channels are appended above the ADC channels
// in the same edge. The engine flags malformed frames, keeps per-channel absolute peak
// meters and runs a programmable periodic IRQ timer.
//
// Optional feature macro: DAFX_FRAME_PEAK_EN
//   defined   -> per-ADC-channel peak meters
//   undefined -> sr_adc_peak tied to 0, cmd_clear_peak ignored
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   adc_data/valid/ready/last ADC beat stream (accepted on valid && ready)
//   synth_data               synth samples, sampled on commit (one slot wide if no synth channels)
//   channel_data             committed frame, channel 0 in the LSBs, ADC channels first
//   fs_strobe                one-cycle pulse in the cycle after a commit
//   sr_frame_counter         committed frames, wraps at 2^32
//   sr_frame_error           sticky malformed-frame flag; cmd_clear_frame_error clears it
//   sr_adc_peak              per-ADC-channel |sample| peak; cmd_clear_peak clears all
//   cr_irq_period            IRQ terminal count, 0 disables the timer
//   irq                      one-cycle periodic interrupt
module dafx_frame_engine #(
  parameter int AUDIO_WIDTH_P          = 24,
  parameter int NR_OF_ADC_CHANNELS_P   = 2,
  parameter int NR_OF_SYNTH_CHANNELS_P = 1,
  parameter int IRQ_COUNTER_WIDTH_P    = 32,
  parameter int IRQ_PERIOD_RESET_P     = 12499999
) (
  input  logic                                                               clk,
  input  logic                                                               rst,
  input  logic [AUDIO_WIDTH_P-1:0]                                           adc_data,
  input  logic                                                               adc_valid,
  output logic                                                               adc_ready,
  input  logic                                                               adc_last,
  input  logic [((NR_OF_SYNTH_CHANNELS_P > 0) ? NR_OF_SYNTH_CHANNELS_P : 1)*AUDIO_WIDTH_P-1:0] synth_data,
  output logic [(NR_OF_ADC_CHANNELS_P+NR_OF_SYNTH_CHANNELS_P)*AUDIO_WIDTH_P-1:0] channel_data,
  output logic                                                               fs_strobe,
  output logic [31:0]                                                        sr_frame_counter,
  output logic                                                               sr_frame_error,
  input  logic                                                               cmd_clear_frame_error,
  output logic [NR_OF_ADC_CHANNELS_P*AUDIO_WIDTH_P-1:0]                      sr_adc_peak,
  input  logic                                                               cmd_clear_peak,
  input  logic [IRQ_COUNTER_WIDTH_P-1:0]                                     cr_irq_period,
  output logic                                                               irq
);

  localparam int W  = AUDIO_WIDTH_P;
  localparam int N  = NR_OF_ADC_CHANNELS_P;
  localparam int S  = NR_OF_SYNTH_CHANNELS_P;
  localparam int NC = N + S;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SH = (N > 1) ? N - 1 : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Elaboration-time parameter sanity checks
  if (N < 1) begin : g_chk_n
    $error("dafx_frame_engine: NR_OF_ADC_CHANNELS_P must be >= 1");
  end
  if ($clog2(IRQ_PERIOD_RESET_P + 1) > IRQ_COUNTER_WIDTH_P) begin : g_chk_irq
    $error("dafx_frame_engine: IRQ_PERIOD_RESET_P does not fit IRQ_COUNTER_WIDTH_P");
  end

  typedef enum logic {ST_COLLECT, ST_RESYNC} state_t;

  state_t                       r_state, w_state_nx;
  logic [IW-1:0]                r_ch_idx, w_ch_idx_nx;
  logic                         r_ready;
  logic [W-1:0]                 r_shadow [SH];
  logic [NC*W-1:0]              r_channel_data;
  logic                         r_fs;
  logic [31:0]                  r_frame_cnt;
  logic                         r_frame_err;
  logic [IRQ_COUNTER_WIDTH_P-1:0] r_irq_cnt;
  logic                         r_irq;

  logic                         w_acc, w_commit, w_err, w_shadow_we;
  logic [N*W-1:0]               w_frame;
  logic [NC*W-1:0]              w_commit_data;

  assign w_acc = adc_valid & r_ready;

  // Frame FSM: next state, channel index and event decode
  always_comb begin
    w_state_nx  = r_state;
    w_ch_idx_nx = r_ch_idx;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_shadow_we = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_acc) begin
          if (r_ch_idx == LAST_IDX) begin
            w_ch_idx_nx = '0;
            if (adc_last) begin
              w_commit = 1'b1;
            end else begin
              // Long frame: drop everything up to the next last beat
              w_err      = 1'b1;
              w_state_nx = ST_RESYNC;
            end
          end else if (adc_last) begin
            // Short frame: discard and restart at channel 0
            w_err       = 1'b1;
            w_ch_idx_nx = '0;
          end else begin
            w_shadow_we = 1'b1;
            w_ch_idx_nx = r_ch_idx + IW'(1);
          end
        end
      end
      ST_RESYNC: begin
        if (w_acc && adc_last) begin
          w_state_nx  = ST_COLLECT;
          w_ch_idx_nx = '0;
        end
      end
      default: w_state_nx = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_COLLECT;
      r_ch_idx <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_ch_idx <= w_ch_idx_nx;
      r_ready  <= 1'b1;
    end
  end

  // Shadow registers hold channels 0..N-2; the final channel comes straight off the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SH; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < N - 1; i++)
        if (w_shadow_we && r_ch_idx == IW'(i)) r_shadow[i] <= adc_data;
    end
  end

  for (genvar i = 0; i < N - 1; i++) begin : g_frame
    assign w_frame[i*W +: W] = r_shadow[i];
  end
  assign w_frame[(N-1)*W +: W] = adc_data;

  if (S > 0) begin : g_syn
    assign w_commit_data = {synth_data[S*W-1:0], w_frame};
  end else begin : g_nosyn
    assign w_commit_data = w_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_channel_data <= '0;
      r_fs           <= 1'b0;
      r_frame_cnt    <= '0;
      r_frame_err    <= 1'b0;
    end else begin
      r_fs <= w_commit;
      if (w_commit) begin
        r_channel_data <= w_commit_data;
        r_frame_cnt    <= r_frame_cnt + 32'd1;
      end
      // A new error in the same cycle as a clear keeps the flag set
      if (w_err)                      r_frame_err <= 1'b1;
      else if (cmd_clear_frame_error) r_frame_err <= 1'b0;
    end
  end

`ifdef DAFX_FRAME_PEAK_EN
  for (genvar c = 0; c < N; c++) begin : g_peak
    logic [W-1:0] r_pk;
    logic [W-1:0] w_s, w_abs, w_base;
    assign w_s = w_frame[c*W +: W];
    // Most negative value has no positive twin; saturate to max positive
    assign w_abs  = !w_s[W-1]                        ? w_s :
                    (w_s == {1'b1, {(W-1){1'b0}}})   ? {1'b0, {(W-1){1'b1}}} : -w_s;
    // Clear first, then fold in the committing sample
    assign w_base = cmd_clear_peak ? '0 : r_pk;
    always_ff @(posedge clk) begin
      if (rst)                 r_pk <= '0;
      else if (w_commit)       r_pk <= (w_abs > w_base) ? w_abs : w_base;
      else if (cmd_clear_peak) r_pk <= '0;
    end
    assign sr_adc_peak[c*W +: W] = r_pk;
  end
`else
  assign sr_adc_peak = '0;
`endif

  // IRQ timer: counts 0..period; >= catches a period lowered below the running count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_cnt <= '0;
      r_irq     <= 1'b0;
    end else if (cr_irq_period == '0) begin
      r_irq_cnt <= '0;
      r_irq     <= 1'b0;
    end else if (r_irq_cnt >= cr_irq_period) begin
      r_irq_cnt <= '0;
      r_irq     <= 1'b1;
    end else begin
      r_irq_cnt <= r_irq_cnt + 1'b1;
      r_irq     <= 1'b0;
    end
  end

  logic w_unused;
  assign w_unused = ^{cmd_clear_peak, synth_data, r_shadow[0]};

  assign adc_ready        = r_ready;
  assign channel_data     = r_channel_data;
  assign fs_strobe        = r_fs;
  assign sr_frame_counter = r_frame_cnt;
  assign sr_frame_error   = r_frame_err;
  assign irq              = r_irq;

endmodule

// File: tb/tb_dafx_frame_engine.sv
module tb_dafx_frame_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u2: N=2, S=1 ; u4: N=4, S=1
  logic [23:0]  d2, d4, syn2, syn4;
  logic         v2, v4, l2, l4;
  logic         rdy2, rdy4, fs2, fs4, err2, err4, irq2, irq4;
  logic [71:0]  cd2;
  logic [119:0] cd4;
  logic [31:0]  fc2, fc4, per2, per4;
  logic [47:0]  pk2;
  logic [95:0]  pk4;
  logic         clr_err, clr_pk;

  dafx_frame_engine #(.NR_OF_ADC_CHANNELS_P(2), .NR_OF_SYNTH_CHANNELS_P(1)) u2 (
    .clk(clk), .rst(rst), .adc_data(d2), .adc_valid(v2), .adc_ready(rdy2), .adc_last(l2),
    .synth_data(syn2), .channel_data(cd2), .fs_strobe(fs2), .sr_frame_counter(fc2),
    .sr_frame_error(err2), .cmd_clear_frame_error(clr_err), .sr_adc_peak(pk2),
    .cmd_clear_peak(clr_pk), .cr_irq_period(per2), .irq(irq2));

  dafx_frame_engine #(.NR_OF_ADC_CHANNELS_P(4), .NR_OF_SYNTH_CHANNELS_P(1)) u4 (
    .clk(clk), .rst(rst), .adc_data(d4), .adc_valid(v4), .adc_ready(rdy4), .adc_last(l4),
    .synth_data(syn4), .channel_data(cd4), .fs_strobe(fs4), .sr_frame_counter(fc4),
    .sr_frame_error(err4), .cmd_clear_frame_error(clr_err), .sr_adc_peak(pk4),
    .cmd_clear_peak(clr_pk), .cr_irq_period(per4), .irq(irq4));

  int n_tests = 0;
  int n_fail  = 0;
  logic [71:0]  q2[$];
  logic [119:0] q4[$];
  int exp_fc2 = 0;
  int exp_fc4 = 0;

  // Scoreboard: every strobe must match the oldest expected frame
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (fs2 === 1'b1) begin
        n_tests++;
        if (q2.size() == 0) begin
          n_fail++; $display("FAIL sb2_unexpected_commit got %h exp none", cd2);
        end else begin
          logic [71:0] e2;
          e2 = q2.pop_front();
          if (cd2 !== e2) begin n_fail++; $display("FAIL sb2_frame got %h exp %h", cd2, e2); end
        end
      end
      if (fs4 === 1'b1) begin
        n_tests++;
        if (q4.size() == 0) begin
          n_fail++; $display("FAIL sb4_unexpected_commit got %h exp none", cd4);
        end else begin
          logic [119:0] e4;
          e4 = q4.pop_front();
          if (cd4 !== e4) begin n_fail++; $display("FAIL sb4_frame got %h exp %h", cd4, e4); end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic beat2(input logic [23:0] d, input logic l);
    d2 = d; l2 = l; v2 = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic idle2();
    v2 = 1'b0; l2 = 1'b0;
  endtask
  task automatic beat4(input logic [23:0] d, input logic l);
    d4 = d; l4 = l; v4 = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic idle4();
    v4 = 1'b0; l4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", rdy2); end
    n_tests++; if (cd2 !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", cd2); end
    n_tests++; if (fs2 !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", fs2); end
    n_tests++; if (fc2 !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", fc2); end
    n_tests++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err2); end
    n_tests++; if (pk2 !== '0) begin n_fail++; $display("FAIL reset_peak got %h exp 0", pk2); end
    n_tests++; if (irq2 !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq2); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (rdy2 !== 1'b1 || rdy4 !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b%b exp 11", rdy2, rdy4); end
  endtask

  task automatic test_basic();
    logic [71:0] e;
    syn2 = 24'h000042;
    e = {24'h000042, 24'hFFFF00, 24'h000100};
    q2.push_back(e); exp_fc2++;
    beat2(24'h000100, 1'b0);
    beat2(24'hFFFF00, 1'b1);
    idle2(); syn2 = 24'h000055;
    n_tests++; if (fs2 !== 1'b1) begin n_fail++; $display("FAIL basic_fs_high got %b exp 1", fs2); end
    n_tests++; if (cd2 !== e) begin n_fail++; $display("FAIL basic_data got %h exp %h", cd2, e); end
    n_tests++; if (fc2 !== 32'(exp_fc2)) begin n_fail++; $display("FAIL basic_cnt got %0d exp %0d", fc2, exp_fc2); end
    @(posedge clk); #1;
    n_tests++; if (fs2 !== 1'b0) begin n_fail++; $display("FAIL basic_fs_pulse got %b exp 0", fs2); end
    n_tests++; if (cd2 !== e) begin n_fail++; $display("FAIL basic_data_hold got %h exp %h", cd2, e); end
  endtask

  task automatic test_back_to_back();
    logic [71:0] e;
    syn2 = 24'h000077;
    q2.push_back({24'h000077, 24'h000002, 24'h000001});
    e = {24'h000077, 24'h000004, 24'h000003};
    q2.push_back(e); exp_fc2 += 2;
    beat2(24'h000001, 1'b0);
    beat2(24'h000002, 1'b1);
    beat2(24'h000003, 1'b0);
    beat2(24'h000004, 1'b1);
    idle2();
    n_tests++; if (fc2 !== 32'(exp_fc2)) begin n_fail++; $display("FAIL b2b_cnt got %0d exp %0d", fc2, exp_fc2); end
    n_tests++; if (cd2 !== e) begin n_fail++; $display("FAIL b2b_data got %h exp %h", cd2, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_short_frame();
    logic [119:0] e1, e2;
    syn4 = 24'h000099;
    e1 = {24'h000099, 24'h000040, 24'h000030, 24'h000020, 24'h000010};
    q4.push_back(e1); exp_fc4++;
    beat4(24'h000010, 1'b0); beat4(24'h000020, 1'b0); beat4(24'h000030, 1'b0); beat4(24'h000040, 1'b1);
    idle4();
    @(posedge clk); #1;
    beat4(24'h0000A1, 1'b0); beat4(24'h0000A2, 1'b1);
    idle4();
    n_tests++; if (err4 !== 1'b1) begin n_fail++; $display("FAIL short_err got %b exp 1", err4); end
    n_tests++; if (cd4 !== e1) begin n_fail++; $display("FAIL short_data_kept got %h exp %h", cd4, e1); end
    n_tests++; if (fc4 !== 32'(exp_fc4)) begin n_fail++; $display("FAIL short_cnt got %0d exp %0d", fc4, exp_fc4); end
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    n_tests++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL short_err_clear got %b exp 0", err4); end
    e2 = {24'h000099, 24'h000080, 24'h000070, 24'h000060, 24'h000050};
    q4.push_back(e2); exp_fc4++;
    beat4(24'h000050, 1'b0); beat4(24'h000060, 1'b0); beat4(24'h000070, 1'b0); beat4(24'h000080, 1'b1);
    idle4();
    n_tests++; if (cd4 !== e2) begin n_fail++; $display("FAIL short_recover_data got %h exp %h", cd4, e2); end
    n_tests++; if (fc4 !== 32'(exp_fc4)) begin n_fail++; $display("FAIL short_recover_cnt got %0d exp %0d", fc4, exp_fc4); end
    @(posedge clk); #1;
  endtask

  task automatic test_long_frame();
    logic [71:0] e;
    e = cd2;
    syn2 = 24'h000033;
    beat2(24'h000005, 1'b0);
    beat2(24'h000006, 1'b0);
    n_tests++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL long_err got %b exp 1", err2); end
    beat2(24'h000007, 1'b0); beat2(24'h000008, 1'b0); beat2(24'h000009, 1'b1);
    idle2();
    @(posedge clk); #1;
    n_tests++; if (fc2 !== 32'(exp_fc2)) begin n_fail++; $display("FAIL long_no_commit got %0d exp %0d", fc2, exp_fc2); end
    n_tests++; if (cd2 !== e) begin n_fail++; $display("FAIL long_data_kept got %h exp %h", cd2, e); end
    e = {24'h000033, 24'h00000B, 24'h00000A};
    q2.push_back(e); exp_fc2++;
    beat2(24'h00000A, 1'b0); beat2(24'h00000B, 1'b1);
    idle2();
    n_tests++; if (cd2 !== e) begin n_fail++; $display("FAIL long_recover_data got %h exp %h", cd2, e); end
    n_tests++; if (fc2 !== 32'(exp_fc2)) begin n_fail++; $display("FAIL long_recover_cnt got %0d exp %0d", fc2, exp_fc2); end
    // Clear coincident with a new (short-frame) error: set wins
    clr_err = 1'b1;
    beat2(24'h00000C, 1'b1);
    idle2(); clr_err = 1'b0;
    n_tests++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL err_set_wins got %b exp 1", err2); end
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    n_tests++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err2); end
  endtask

  task automatic test_peak();
    logic [47:0] e1, e2, e3;
`ifdef DAFX_FRAME_PEAK_EN
    e1 = {24'h000005, 24'h7FFFF0};
    e2 = {24'h000005, 24'h7FFFFF};
    e3 = {24'h000003, 24'h000010};
`else
    e1 = '0; e2 = '0; e3 = '0;
`endif
    syn2 = 24'h000011;
    clr_pk = 1'b1; @(posedge clk); #1; clr_pk = 1'b0;
    n_tests++; if (pk2 !== 48'd0) begin n_fail++; $display("FAIL peak_clear got %h exp 0", pk2); end
    q2.push_back({24'h000011, 24'h000005, 24'h7FFFF0}); exp_fc2++;
    beat2(24'h7FFFF0, 1'b0); beat2(24'h000005, 1'b1); idle2();
    n_tests++; if (pk2 !== e1) begin n_fail++; $display("FAIL peak_pos got %h exp %h", pk2, e1); end
    q2.push_back({24'h000011, 24'hFFFFFE, 24'h800000}); exp_fc2++;
    beat2(24'h800000, 1'b0); beat2(24'hFFFFFE, 1'b1); idle2();
    n_tests++; if (pk2 !== e2) begin n_fail++; $display("FAIL peak_sat got %h exp %h", pk2, e2); end
    q2.push_back({24'h000011, 24'h000003, 24'h000010}); exp_fc2++;
    beat2(24'h000010, 1'b0);
    clr_pk = 1'b1;
    beat2(24'h000003, 1'b1); idle2();
    clr_pk = 1'b0;
    n_tests++; if (pk2 !== e3) begin n_fail++; $display("FAIL peak_clear_commit got %h exp %h", pk2, e3); end
    n_tests++; if (fc2 !== 32'(exp_fc2)) begin n_fail++; $display("FAIL peak_cnt got %0d exp %0d", fc2, exp_fc2); end
    @(posedge clk); #1;
  endtask

  task automatic test_irq();
    int k;
    per2 = 32'd0;
    repeat (2) @(posedge clk);
    #1; per2 = 32'd9;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (irq2 !== 1'b1 && k < 40);
    n_tests++; if (k != 10) begin n_fail++; $display("FAIL irq_first got %0d exp 10 cycles", k); end
    @(posedge clk); #1;
    n_tests++; if (irq2 !== 1'b0) begin n_fail++; $display("FAIL irq_pulse got %b exp 0", irq2); end
    k = 1;
    do begin @(posedge clk); #1; k++; end while (irq2 !== 1'b1 && k < 40);
    n_tests++; if (k != 10) begin n_fail++; $display("FAIL irq_period got %0d exp 10 cycles", k); end
    // Counter is 0 now; after 7 edges it holds 7, then lower the period below it
    k = 0;
    repeat (7) begin @(posedge clk); #1; if (irq2 === 1'b1) k++; end
    per2 = 32'd3;
    n_tests++; if (k != 0) begin n_fail++; $display("FAIL irq_early got %0d exp 0 pulses", k); end
    @(posedge clk); #1;
    n_tests++; if (irq2 !== 1'b1) begin n_fail++; $display("FAIL irq_lowered got %b exp 1", irq2); end
    per2 = 32'd0;
    @(posedge clk); #1;
    k = 0;
    repeat (100) begin @(posedge clk); #1; if (irq2 === 1'b1) k++; end
    n_tests++; if (k != 0) begin n_fail++; $display("FAIL irq_disabled got %0d exp 0 pulses", k); end
  endtask

  task automatic test_rst_mid();
    logic [71:0] e;
    syn2 = 24'h000066;
    beat2(24'hAAAAAA, 1'b0);
    idle2();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    exp_fc2 = 0; exp_fc4 = 0;
    @(posedge clk); #1;
    e = {24'h000066, 24'h222222, 24'h111111};
    q2.push_back(e); exp_fc2++;
    beat2(24'h111111, 1'b0); beat2(24'h222222, 1'b1); idle2();
    n_tests++; if (cd2 !== e) begin n_fail++; $display("FAIL rst_mid_data got %h exp %h", cd2, e); end
    n_tests++; if (fc2 !== 32'(exp_fc2)) begin n_fail++; $display("FAIL rst_mid_cnt got %0d exp %0d", fc2, exp_fc2); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; d2 = '0; d4 = '0; v2 = 1'b0; v4 = 1'b0; l2 = 1'b0; l4 = 1'b0;
    syn2 = '0; syn4 = '0; clr_err = 1'b0; clr_pk = 1'b0; per2 = '0; per4 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_peak();
    test_irq();
    test_rst_mid();
    n_tests++; if (q2.size() != 0 || q4.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got %0d/%0d pending exp 0/0", q2.size(), q4.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dafx_frame_engine.md
# dafx_frame_engine

Parametrised audio frame engine between the CS5343 ADC/DAC stream interface and the mixer.
- Deserialises an N-channel ADC stream into aligned channel vectors and generates the sample-rate strobe.
- Latches synthesiser channels into the same frame, detects malformed frames and keeps per-channel peak meters.
- Generates a programmable periodic IRQ.
- Replaces fixed two-channel ADC capture and fixed-period IRQ counters in the DAFX top level.

## Interface
- AUDIO_WIDTH_P, 24, sample width, signed two's complement
- NR_OF_ADC_CHANNELS_P, 2, ADC channels per frame (≥1)
- NR_OF_SYNTH_CHANNELS_P, 1, internally generated channels appended after ADC channels (≥0)
- IRQ_COUNTER_WIDTH_P, 32, IRQ timer width
- IRQ_PERIOD_RESET_P, 12499999, IRQ terminal count after reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- adc_data  in  AUDIO_WIDTH_P  ADC sample beat
- adc_valid  in  1  beat valid
- adc_ready  out  1  beat ready
- adc_last  in  1  final beat of frame
- synth_data  in  NR_OF_SYNTH_CHANNELS_P×AUDIO_WIDTH_P  synthesiser samples
- channel_data  out  (NR_OF_ADC_CHANNELS_P+NR_OF_SYNTH_CHANNELS_P)×AUDIO_WIDTH_P  committed frame, ADC channels first
- fs_strobe  out  1  frame committed pulse
- sr_frame_counter  out  32  committed frames
- sr_frame_error  out  1  sticky malformed-frame flag
- cmd_clear_frame_error  in  1  clears sr_frame_error
- sr_adc_peak  out  NR_OF_ADC_CHANNELS_P×AUDIO_WIDTH_P  per-channel absolute peak
- cmd_clear_peak  in  1  clears all peaks
- cr_irq_period  in  IRQ_COUNTER_WIDTH_P  IRQ terminal count; 0 disables the timer
- irq  out  1  periodic interrupt pulse

## Operation
- Handshake: a beat is accepted when adc_valid && adc_ready.
  - adc_ready is 0 in reset and 1 from the first cycle after rst deasserts.
- Channel index ch_idx is 0 after reset and selects which shadow register an accepted beat writes.
- State COLLECT:
  - Accepted, !last, ch_idx<N-1: write shadow[ch_idx]; ch_idx+1.
  - Accepted, last, ch_idx==N-1: commit. All shadows plus this beat go to channel_data[0..N-1]; synth_data is sampled into the upper slots in the same edge; fs_strobe pulses; sr_frame_counter+1 (wraps at 2^32); ch_idx←0.
  - Accepted, last, ch_idx<N-1 (short frame): discard; sr_frame_error←1; ch_idx←0; channel_data unchanged.
  - Accepted, !last, ch_idx==N-1 (long frame): discard; sr_frame_error←1; go to RESYNC.
- State RESYNC: accepted beats are dropped. An accepted beat with last returns to COLLECT with ch_idx←0, with no commit.
- Peak meters (per ADC channel):
  - On commit, peak←max(peak, |sample|).
  - |−2^(W−1)| saturates to 2^(W−1)−1.
  - If cmd_clear_peak and a commit occur in the same cycle, peak←|sample| (clear, then update).
- Frame error: cmd_clear_frame_error clears the flag. If a new error occurs in the same cycle, set wins.
- IRQ timer:
  - Counter counts 0..cr_irq_period. On reaching cr_irq_period (or above it, after the period is lowered), irq pulses one cycle and the counter returns to 0.
  - cr_irq_period==0 holds the counter at 0 with no pulses.
  - cr_irq_period is a port; IRQ_PERIOD_RESET_P is the value the register block drives after reset.

## Timing
- Reset values: adc_ready 0, channel_data 0, fs_strobe 0, sr_frame_counter 0, sr_frame_error 0, sr_adc_peak 0, irq 0. State is COLLECT, ch_idx 0, IRQ counter 0.
- Commit latency: last beat accepted at edge E. channel_data, sr_frame_counter and sr_adc_peak update at E. fs_strobe is high for exactly the cycle after E.
- Back-to-back frames: a new beat may be accepted in the cycle fs_strobe is high.
- irq is high for exactly one cycle every cr_irq_period+1 cycles.
- rst mid-frame: partial shadows are discarded, state returns to COLLECT, and the next beat is treated as channel 0.

## Configuration
- DAFX_FRAME_PEAK_EN defined: peak meters are implemented as described.
- DAFX_FRAME_PEAK_EN undefined: no peak logic; sr_adc_peak is tied to 0 and cmd_clear_peak is ignored.

## Test plan
- N=2, S=1. Beats 0x000100 (last=0), 0xFFFF00 (last=1), synth_data=0x000042 → next cycle channel_data = {0x000042, 0xFFFF00, 0x000100}; fs_strobe one cycle; sr_frame_counter=1.
- N=4. Frame with last on beat 2 → sr_frame_error=1, channel_data unchanged. Following well-formed 4-beat frame commits correctly.
- N=2. Five beats, last only on beat 5 → error set, RESYNC drops beats 3–5, no commit. Next 2-beat frame commits.
- Peak: samples 0x7FFFF0 then 0x800000 on channel 0 → peak 0x7FFFFF. Clear simultaneous with commit of 0x000010 → peak 0x000010.
- cr_irq_period=9 → irq every 10 cycles. Change to 3 when counter=7 → irq next cycle. Set to 0 → no irq for 100 cycles.
- Assert rst after one beat of a 2-channel frame. After release, beats A (last=0), B (last=1) → channel_data={B, A}.
